// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch resolver: compares operands CHUNK bits per cycle, MSB-first,
// with early exit, then reports taken/flags/target/mispredict behind valid/ready.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      br_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_out,
  output logic            eq,
  output logic            ne,
  output logic            lt,
  output logic            ge,
  output logic            illegal,
  output logic            mispredict,
  output logic [XLEN-1:0] target
);

  localparam int N     = XLEN / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [XLEN-1:0]   a_p0, b_p0;
  logic [2:0]        ctrl_p0;
  logic              pred_p0;
  logic              accept;
  logic [CHUNK-1:0]  a_top, b_top;
  logic              chunk_eq, lt_u, cmp_last, taken;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [XLEN-1:0] bias_msb(input logic [XLEN-1:0] x, input logic is_signed);
    logic [XLEN-1:0] r;
    r = x;
    r[XLEN-1] = x[XLEN-1] ^ is_signed;
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] ctrl, input logic eq_f, input logic lt_f);
    logic t;
    case (ctrl)
      3'b000:          t = eq_f;
      3'b001:          t = !eq_f;
      3'b100, 3'b110:  t = lt_f;
      3'b101, 3'b111:  t = !lt_f;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  assign in_ready = !rst && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Operands shift left each CMP cycle so the compared chunk is always the top one.
  assign a_top    = a_p0[XLEN-1 -: CHUNK];
  assign b_top    = b_p0[XLEN-1 -: CHUNK];
  assign chunk_eq = (a_top == b_top);
  assign lt_u     = !chunk_eq && (a_top < b_top);
  assign cmp_last = !chunk_eq || (idx == '0);
  assign taken    = branch_taken(ctrl_p0, chunk_eq, lt_u);

  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CMP;
      CMP:     if (cmp_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Stage p0: captured operands and branch attributes
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= bias_msb(src_a, !br_ctrl[1]);
      b_p0    <= bias_msb(src_b, !br_ctrl[1]);
      ctrl_p0 <= br_ctrl;
      pred_p0 <= pred_taken;
    end else if (state == CMP) begin
      a_p0 <= a_p0 << CHUNK;
      b_p0 <= b_p0 << CHUNK;
    end
  end

  // Stage p1: control state and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      br_out     <= 1'b0;
      eq         <= 1'b0;
      ne         <= 1'b0;
      lt         <= 1'b0;
      ge         <= 1'b0;
      illegal    <= 1'b0;
      mispredict <= 1'b0;
      target     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx    <= IDX_W'(N - 1);
        target <= pc + imm;
      end else if ((state == CMP) && !flush) begin
        if (cmp_last) begin
          eq         <= chunk_eq;
          ne         <= !chunk_eq;
          lt         <= lt_u;
          ge         <= !lt_u;
          br_out     <= taken;
          illegal    <= (ctrl_p0[2:1] == 2'b01);
          mispredict <= taken ^ pred_p0;
        end else begin
          idx <= idx - IDX_W'(1);
        end
      end
    end
  end

endmodule
